// File: rtl/logic_reduce_pkg.sv
// Shared op codes, FSM encoding and op decode helpers for the logic reduce accumulator.
package logic_reduce_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_op_t;

    function automatic logic is_inverting(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_XNOR;
    endfunction

    // Reserved codes fall through to AND.
    function automatic base_op_t base_op(input logic [2:0] op);
        base_op_t b;
        case (op)
            OP_OR, OP_NOR:   b = BASE_OR;
            OP_XOR, OP_XNOR: b = BASE_XOR;
            default:         b = BASE_AND;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/logic_reduce_acc_if.sv
// Stream-in / result-out bundle for logic_reduce_acc; slave is the block's view.
interface logic_reduce_acc_if
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
);
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_bit;
    logic [CW-1:0]    out_count;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output op, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_bit, out_count, out_ovf, out_err
    );

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_bit, out_count, out_ovf, out_err
    );

endinterface

// File: rtl/logic_reduce_acc_op_core.sv
// Combinational two-operand bitwise gate over the base (non-inverting) op.
module logic_op_core
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  base_op_t         base,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (base)
            BASE_OR:  y = a | b;
            BASE_XOR: y = a ^ b;
            default:  y = a & b;
        endcase
    end

endmodule

// File: rtl/logic_reduce_acc.sv
// Folds a packet of WIDTH-bit beats with a selectable bitwise op into one result word.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | waiting for first beat; captures op, data, count=1
//  ST_ACC  | folding further beats; closes on in_last or at MAX_BEATS
//  ST_HOLD | result presented; input stalled until out_ready
module logic_reduce_acc
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input logic               clk,
    input logic               rst,
    logic_reduce_acc_if.slave bus
);

    localparam int            CW      = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] res;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic             ovf;
    logic             accept;
    logic             at_max;
    base_op_t         base_q;

    assign accept  = bus.in_valid && (state != ST_HOLD);
    assign cnt_inc = cnt + CW'(1);
    assign at_max  = (cnt_inc == CNT_MAX);
    assign base_q  = base_op(op_q);

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .base (base_q),
        .a    (acc),
        .b    (bus.in_data),
        .y    (fold)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = bus.in_last ? ST_HOLD : ST_ACC;
            ST_ACC:  if (accept && (bus.in_last || at_max)) state_nxt = ST_HOLD;
            ST_HOLD: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            op_q <= OP_AND;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                acc  <= bus.in_data;
                op_q <= bus.op;
                cnt  <= CW'(1);
                ovf  <= 1'b0;
            end else begin
                acc <= fold;
                cnt <= cnt_inc;
                ovf <= at_max && !bus.in_last;
            end
        end
    end

    // Inversion is applied once here, after the whole packet is folded.
    assign res = is_inverting(op_q) ? ~acc : acc;

    always_comb begin
        bus.out_bit = 1'b0;
        case (base_q)
            BASE_OR:  bus.out_bit = |res;
            BASE_XOR: bus.out_bit = ^res;
            default:  bus.out_bit = &res;
        endcase
    end

    assign bus.in_ready  = (state != ST_HOLD);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_data  = res;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;
    assign bus.out_err   = is_reserved(op_q);

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed self-checking bench for logic_reduce_acc (WIDTH=8, MAX_BEATS=4).
module tb_logic_reduce_acc;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic_reduce_acc_if #(.WIDTH(8), .MAX_BEATS(4)) bus ();

    logic_reduce_acc #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one beat, waits (bounded) for acceptance, returns #1 after the accepting edge.
    task automatic beat(input string tag, input logic [2:0] o, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        bus.op       = o;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [7:0] d, input logic b,
                           input logic [2:0] c, input logic o, input logic e);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
        chk({tag, "_bit"},   32'(bus.out_bit),   32'(b));
        chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
        chk({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
        chk({tag, "_err"},   32'(bus.out_err),   32'(e));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"},      32'(bus.out_data),  32'd0);
        chk({tag, "_bit"},       32'(bus.out_bit),   32'd0);
        chk({tag, "_count"},     32'(bus.out_count), 32'd0);
        chk({tag, "_ovf"},       32'(bus.out_ovf),   32'd0);
        chk({tag, "_err"},       32'(bus.out_err),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.op        = 3'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: AND fold; result appears the cycle after the last beat
        beat("t1b0", 3'd0, 8'hFF, 1'b0);
        beat("t1b1", 3'd0, 8'hF0, 1'b0);
        chk("t1_not_yet", 32'(bus.out_valid), 32'd0);
        beat("t1b2", 3'd0, 8'h3C, 1'b1);
        chk("t1_latency", 32'(bus.out_valid), 32'd1);
        collect("t1", 8'h30, 1'b0, 3'd3, 1'b0, 1'b0);

        // 2: NAND single beat, then XNOR pair
        beat("t2a", 3'd3, 8'hFF, 1'b1);
        collect("t2a", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
        beat("t2b0", 3'd5, 8'hAA, 1'b0);
        beat("t2b1", 3'd5, 8'h0F, 1'b1);
        collect("t2b", 8'h5A, 1'b0, 3'd2, 1'b0, 1'b0);

        // 3: forced close at MAX_BEATS, fifth beat starts a new packet
        beat("t3b0", 3'd1, 8'h01, 1'b0);
        beat("t3b1", 3'd1, 8'h02, 1'b0);
        beat("t3b2", 3'd1, 8'h04, 1'b0);
        beat("t3b3", 3'd1, 8'h08, 1'b0);
        collect("t3a", 8'h0F, 1'b1, 3'd4, 1'b1, 1'b0);
        beat("t3b4", 3'd1, 8'h10, 1'b1);
        collect("t3b", 8'h10, 1'b1, 3'd1, 1'b0, 1'b0);

        // 4: backpressure in HOLD with a beat offered meanwhile
        beat("t4b0", 3'd1, 8'h11, 1'b1);
        bus.op       = 3'd2;
        bus.in_data  = 8'h07;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_ready", 32'(bus.in_ready),  32'd0);
            chk("t4_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_stall_data",  32'(bus.out_data),  32'h11);
            chk("t4_stall_count", 32'(bus.out_count), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("t4_handoff_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        collect("t4b", 8'h07, 1'b1, 3'd1, 1'b0, 1'b0);

        // 5: reset mid-packet discards the partial fold
        beat("t5b0", 3'd2, 8'h01, 1'b0);
        beat("t5b1", 3'd2, 8'h02, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("t5rst");
        rst = 1'b0;
        beat("t5b2", 3'd2, 8'h55, 1'b1);
        collect("t5", 8'h55, 1'b0, 3'd1, 1'b0, 1'b0);

        // 6: reserved op behaves as AND with error flag; mid-packet op change ignored
        beat("t6b0", 3'd7, 8'hF0, 1'b0);
        beat("t6b1", 3'd1, 8'h3C, 1'b1);
        collect("t6", 8'h30, 1'b0, 3'd2, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
